// File: rtl/apb_slv_mem.sv
// rtl/apb_slv_mem.sv - APB3 completer backed by a word-addressed register array
// Optional wait states per transfer are enabled with `define APB_SLV_WAIT_EN.
module apb_slv_mem #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr
);

    localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] LP_LIMIT = ADDR_W'(DEPTH * 4);

    typedef enum logic {
        ST_IDLE,
        ST_ACCESS
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [IDX_W-1:0]  r_idx;
    logic              r_write;
    logic              r_err;
    logic              w_setup;
    logic              w_commit;
    logic              w_wait_done;
    logic              w_addr_err;

    assign w_addr_err = (paddr[1:0] != 2'b00) || (paddr >= LP_LIMIT);

`ifdef APB_SLV_WAIT_EN
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    logic [CNT_W-1:0] r_wait;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait <= '0;
        end else if (w_setup) begin
            r_wait <= CNT_W'(WAIT_CYCLES);
        end else if (r_state == ST_ACCESS && psel && r_wait != '0) begin
            r_wait <= r_wait - CNT_W'(1);
        end
    end

    assign w_wait_done = (r_wait == '0);
`else
    logic w_unused_wait;

    assign w_unused_wait = (WAIT_CYCLES != 0);
    assign w_wait_done   = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Access without a preceding setup is ignored: IDLE only leaves on a setup phase.
    always_comb begin
        w_state_nxt = r_state;
        w_setup     = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (psel && !penable) begin
                    w_setup     = 1'b1;
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!psel) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_wait_done) begin
                    w_state_nxt = ST_IDLE;
                    w_commit    = penable && r_write && !r_err;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx   <= '0;
            r_write <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_setup) begin
            r_idx   <= paddr[IDX_W+1:2];
            r_write <= pwrite;
            r_err   <= w_addr_err;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_commit) begin
            r_mem[r_idx] <= pwdata;
        end
    end

    // Responses depend only on registered state and the latched address, never on pwdata.
    assign pready  = (r_state == ST_ACCESS) && w_wait_done;
    assign pslverr = pready && r_err;
    assign prdata  = (pready && !r_write && !r_err) ? r_mem[r_idx] : '0;

endmodule

// File: tb/tb_apb_slv_mem.sv
// tb/tb_apb_slv_mem.sv - directed table-driven bench for apb_slv_mem
module tb_apb_slv_mem;

    localparam int WAITS = 2;
`ifdef APB_SLV_WAIT_EN
    localparam int LAT = 1 + WAITS;
`else
    localparam int LAT = 1;
`endif
    localparam int NVEC = 11;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int n_pass = 0;
    int n_total = 0;

    logic [31:0] model [16];

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [NVEC];

    apb_slv_mem #(
        .ADDR_W(32),
        .DATA_W(32),
        .DEPTH(16),
        .WAIT_CYCLES(WAITS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .psel(psel),
        .penable(penable),
        .pwrite(pwrite),
        .paddr(paddr),
        .pwdata(pwdata),
        .prdata(prdata),
        .pready(pready),
        .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Starts just after a rising edge and ends just after the completing edge,
    // so consecutive calls produce back-to-back transfers.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic err, output int lat,
                        output time t);
        logic seen;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wd;
        @(posedge clk);
        #1 penable = 1'b1;
        lat  = 0;
        rd   = '0;
        err  = 1'b0;
        t    = 0;
        seen = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            lat++;
            if (pready) begin
                rd   = prdata;
                err  = pslverr;
                t    = $time;
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("pready_timeout", 32'(pready), 32'h1);
        @(posedge clk);
        #1;
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    logic [31:0] rd;
    logic        err;
    int          lat;
    time         t0, t1, t2;

    initial begin
        vecs[0]  = '{1'b1, 32'h08, 32'hDEADBEEF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 32'h08, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b0, 32'h40, 32'h0,        32'h0,        1'b1};
        vecs[3]  = '{1'b1, 32'h40, 32'h11111111, 32'h0,        1'b1};
        vecs[4]  = '{1'b1, 32'h05, 32'h22222222, 32'h0,        1'b1};
        vecs[5]  = '{1'b0, 32'h04, 32'h0,        32'h0,        1'b0};
        vecs[6]  = '{1'b0, 32'h3C, 32'h0,        32'h0,        1'b0};
        vecs[7]  = '{1'b1, 32'h3C, 32'hCAFEF00D, 32'h0,        1'b0};
        vecs[8]  = '{1'b0, 32'h3C, 32'h0,        32'hCAFEF00D, 1'b0};
        vecs[9]  = '{1'b0, 32'h3E, 32'h0,        32'h0,        1'b1};
        vecs[10] = '{1'b0, 32'h08, 32'h0,        32'hDEADBEEF, 1'b0};
        for (int i = 0; i < 16; i++) model[i] = '0;

        #2;
        chk("reset_pready", 32'(pready), 32'h0);
        chk("reset_pslverr", 32'(pslverr), 32'h0);
        chk("reset_prdata", prdata, 32'h0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, err, lat, t0);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT));
            chk($sformatf("vec%0d_prdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_pslverr", i), 32'(err), 32'(vecs[i].exp_err));
            if (vecs[i].wr && !vecs[i].exp_err) model[vecs[i].addr[5:2]] = vecs[i].wdata;
        end

        for (int w = 0; w < 16; w++) begin
            xfer(1'b0, 32'(w * 4), 32'h0, rd, err, lat, t0);
            chk($sformatf("sweep_word%0d", w), rd, model[w]);
        end

        xfer(1'b1, 32'h00, 32'h00000A0A, rd, err, lat, t0);
        xfer(1'b1, 32'h04, 32'h00000B0B, rd, err, lat, t1);
        xfer(1'b1, 32'h08, 32'h00000C0C, rd, err, lat, t2);
        model[0] = 32'h00000A0A;
        model[1] = 32'h00000B0B;
        model[2] = 32'h00000C0C;
        chk("b2b_gap01", 32'(t1 - t0), 32'((LAT + 1) * 10));
        chk("b2b_gap12", 32'(t2 - t1), 32'((LAT + 1) * 10));
        for (int w = 0; w < 3; w++) begin
            xfer(1'b0, 32'(w * 4), 32'h0, rd, err, lat, t0);
            chk($sformatf("b2b_readback%0d", w), rd, model[w]);
        end

        psel    = 1'b1;
        penable = 1'b1;
        pwrite  = 1'b1;
        paddr   = 32'h10;
        pwdata  = 32'h00000BAD;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("noset_pready%0d", c), 32'(pready), 32'h0);
        end
        @(posedge clk);
        #1 psel = 1'b0;
        penable = 1'b0;
        xfer(1'b0, 32'h10, 32'h0, rd, err, lat, t0);
        chk("noset_no_write", rd, model[4]);

        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h04;
        pwdata  = 32'hFFFF0000;
        @(posedge clk);
        #1 psel = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_pready", 32'(pready), 32'h0);
        @(posedge clk);
        #1;
        xfer(1'b0, 32'h04, 32'h0, rd, err, lat, t0);
        chk("abort_no_write", rd, model[1]);

        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h00;
        pwdata  = 32'hA5A5A5A5;
        @(posedge clk);
        #1 penable = 1'b1;
        #2 reset = 1'b1;
        #1;
        chk("midrst_pready", 32'(pready), 32'h0);
        chk("midrst_prdata", prdata, 32'h0);
        chk("midrst_pslverr", 32'(pslverr), 32'h0);
        @(posedge clk);
        #1 psel = 1'b0;
        penable = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = '0;
        xfer(1'b0, 32'h00, 32'h0, rd, err, lat, t0);
        chk("midrst_read0", rd, 32'h0);
        chk("midrst_lat", 32'(lat), 32'(LAT));
        xfer(1'b0, 32'h08, 32'h0, rd, err, lat, t0);
        chk("midrst_cleared8", rd, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
